// File: rtl/ctrl_unit_pkg.sv
// Shared definitions for the ctrl_unit core: datapath widths, opcode set,
// instruction word layout and the small decode helpers used by the FSM.
package ctrl_unit_pkg;

    localparam int XLEN = 8;
    localparam int ILEN = 16;
    localparam int NREGS = 4;

    typedef enum logic [3:0] {
        OP_AND   = 4'd0,
        OP_OR    = 4'd1,
        OP_ADD   = 4'd2,
        OP_SUB   = 4'd3,
        OP_INC   = 4'd4,
        OP_DEC   = 4'd5,
        OP_COMP  = 4'd6,
        OP_CHECK = 4'd7,
        OP_LOAD  = 4'd8,
        OP_STORE = 4'd9,
        OP_LI    = 4'd10,
        OP_R_90  = 4'd11,
        OP_R_180 = 4'd12,
        OP_JZ    = 4'd13,
        OP_JMP   = 4'd14,
        OP_HALT  = 4'd15
    } opcode_t;

    // Instruction word: [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm
    typedef struct packed {
        opcode_t    op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [7:0] imm;
    } instr_t;

    // Instructions that spend an extra cycle in MEM
    function automatic logic is_mem_op(input opcode_t op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    // Instructions whose ALU result is written back into R[rd]
    function automatic logic writes_reg(input opcode_t op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_INC, OP_DEC,
            OP_LI, OP_LOAD, OP_R_90, OP_R_180: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

    // Instructions that capture the ALU zero flag into zflag
    function automatic logic writes_flag(input opcode_t op);
        return (op == OP_COMP) || (op == OP_CHECK);
    endfunction

    // True when the instruction redirects the pc to its immediate
    function automatic logic takes_branch(input opcode_t op, input logic zflag);
        return (op == OP_JMP) || ((op == OP_JZ) && zflag);
    endfunction

endpackage

// File: rtl/regfile4x8.sv
// Four-entry, 8-bit register file: two asynchronous read ports and one
// synchronous write port, cleared by the synchronous reset.
module regfile4x8
    import ctrl_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      raddr0,
    output logic [XLEN-1:0] rdata0,
    input  logic [1:0]      raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic            we,
    input  logic [1:0]      waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] regs [NREGS];

    // Register storage: cleared on reset, otherwise one write per cycle when enabled
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata0 = regs[raddr0];
    assign rdata1 = regs[raddr1];

endmodule

// File: rtl/ctrl_unit.sv
// Multi-cycle control unit: fetches 16-bit instructions, sequences them
// through FETCH/DECODE/EXEC/MEM/WB, drives an external ALU and data memory,
// and writes results back into a four-entry register file.
module ctrl_unit
    import ctrl_unit_pkg::*;
#(
    parameter int IMEM_AW = 8,
    parameter int DMEM_AW = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [ILEN-1:0]    imem_data,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [XLEN-1:0]    dmem_wdata,
    output logic               dmem_we,
    input  logic [XLEN-1:0]    dmem_rdata,
    output logic [3:0]         alu_op,
    output logic [XLEN-1:0]    alu_in0,
    output logic [XLEN-1:0]    alu_in1,
    input  logic [XLEN-1:0]    alu_out,
    input  logic               alu_zf,
    output logic               halted,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t             state;
    logic [IMEM_AW-1:0] pc;
    logic [IMEM_AW-1:0] pc_next;
    instr_t             ir;
    instr_t             fetched;
    instr_t             cur;
    logic               zflag;
    logic               we_q;
    logic [XLEN-1:0]    rd_val;
    logic [XLEN-1:0]    rs_val;
    logic [XLEN-1:0]    op_in0;
    logic [XLEN-1:0]    op_in1;
    logic               rf_we;

    assign imem_addr = pc;
    assign fetched   = instr_t'(imem_data);

    // In DECODE the operands are read straight from the incoming word so the
    // ALU inputs are already registered and stable when EXEC begins.
    assign cur = (state == S_DECODE) ? fetched : ir;

    // The write strobe is masked by rst so a reset landing in MEM abandons the store
    assign dmem_we = we_q & ~rst;

    assign rf_we = (state == S_WB) && writes_reg(ir.op);

    regfile4x8 u_regfile (
        .clk    (clk),
        .rst    (rst),
        .raddr0 (cur.rd),
        .rdata0 (rd_val),
        .raddr1 (cur.rs),
        .rdata1 (rs_val),
        .we     (rf_we),
        .waddr  (ir.rd),
        .wdata  (alu_out)
    );

    // Operand selection for the ALU according to the opcode being decoded
    always_comb begin
        op_in0 = '0;
        op_in1 = '0;
        case (cur.op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_COMP: begin
                op_in0 = rd_val;
                op_in1 = rs_val;
            end
            OP_INC, OP_DEC: begin
                op_in0 = rd_val;
            end
            OP_CHECK: begin
                op_in0 = rd_val;
                op_in1 = cur.imm;
            end
            OP_LI: begin
                op_in0 = cur.imm;
            end
            OP_R_90, OP_R_180: begin
                op_in0 = cur.imm;
                op_in1 = rs_val;
            end
            default: begin
                op_in0 = '0;
                op_in1 = '0;
            end
        endcase
    end

    // Next pc at write-back: jump target or sequential successor (wraps naturally)
    always_comb begin
        pc_next = pc + IMEM_AW'(1);
        if (takes_branch(ir.op, zflag)) begin
            pc_next = IMEM_AW'(ir.imm);
        end
    end

    // Main sequencer with all externally visible control outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            pc         <= '0;
            ir         <= '0;
            zflag      <= 1'b0;
            we_q       <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            alu_op     <= '0;
            alu_in0    <= '0;
            alu_in1    <= '0;
            halted     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (run) begin
                        pc    <= '0;
                        busy  <= 1'b1;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    ir      <= fetched;
                    alu_op  <= fetched.op;
                    alu_in0 <= op_in0;
                    alu_in1 <= op_in1;
                    if (is_mem_op(fetched.op)) begin
                        dmem_addr <= DMEM_AW'(rs_val);
                    end
                    if (fetched.op == OP_STORE) begin
                        dmem_wdata <= rd_val;
                    end
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (ir.op == OP_HALT) begin
                        busy   <= 1'b0;
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else if (is_mem_op(ir.op)) begin
                        we_q  <= (ir.op == OP_STORE);
                        state <= S_MEM;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (ir.op == OP_LOAD) begin
                        alu_in0 <= dmem_rdata;
                    end
                    state <= S_WB;
                end
                S_WB: begin
                    if (writes_flag(ir.op)) begin
                        zflag <= alu_zf;
                    end
                    pc    <= pc_next;
                    state <= S_FETCH;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ctrl_unit.md
CTRL_UNIT -- requirements
Module: ctrl_unit

Interface
REQ-001 SHALL have parameter IMEM_AW, default 8, meaning instruction address width.
REQ-002 SHALL have parameter DMEM_AW, default 8, meaning data address width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 run  in  1  start pulse; honoured only in IDLE.
REQ-006 imem_addr  out  IMEM_AW  instruction fetch address (= pc).
REQ-007 imem_data  in  16  instruction word; valid one cycle after imem_addr is presented.
REQ-008 dmem_addr  out  DMEM_AW  data address; dmem_wdata out 8; dmem_we out 1; dmem_rdata in 8, valid one cycle after address.
REQ-009 alu_op  out  4; alu_in0  out  8; alu_in1  out  8; all driven to the downstream ALU.
REQ-010 alu_out  in  8; alu_zf  in  1; combinational results returned by the ALU.
REQ-011 halted  out  1  high while in HALT; busy  out  1  high in any state except IDLE and HALT.

Function
REQ-012 Instruction format: [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm.
REQ-013 Register file: four 8-bit registers R0-R3, internal; flag register zflag, 1 bit.
REQ-014 FSM states: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-015 IDLE->FETCH on run=1; pc cleared to 0 on that transition.
REQ-016 FETCH: drive imem_addr=pc; next DECODE. DECODE: latch imem_data into ir; next EXEC.
REQ-017 EXEC: drive alu_op/alu_in0/alu_in1 from ir; LOAD and STORE go to MEM, all others to WB.
REQ-018 Operand mapping: AND/OR/ADD/SUB/COMP: in0=R[rd], in1=R[rs]; INC/DEC: in0=R[rd], in1=0; CHECK: in0=R[rd], in1=imm; LI: in0=imm; R_90/R_180: in0=imm (face select), in1=R[rs].
REQ-019 MEM: dmem_addr=R[rs]; STORE asserts dmem_we for exactly one cycle with dmem_wdata=R[rd]; LOAD waits one cycle, then drives alu_in0=dmem_rdata with alu_op=LOAD; next WB.
REQ-020 WB: R[rd]<=alu_out for AND, OR, ADD, SUB, INC, DEC, LI, LOAD, R_90, R_180; no register write for COMP, CHECK, STORE.
REQ-021 WB: zflag<=alu_zf for COMP and CHECK only; unchanged otherwise.
REQ-022 WB: JZ (op 13) sets pc<=imm if zflag=1, else pc+1; JMP (op 14) sets pc<=imm; others pc<=pc+1; next FETCH.
REQ-023 HALT (op 15): from EXEC go directly to HALT; remain there until rst.
REQ-024 pc increment wraps modulo 2^IMEM_AW; 8-bit arithmetic wraps in the ALU and is not checked here.
REQ-025 Fixed instruction latency: 5 cycles (FETCH, DECODE, EXEC, MEM, WB) for LOAD/STORE, 4 for all others.
REQ-026 alu_op, alu_in0 and alu_in1 are registered outputs and stay stable from EXEC through WB.
REQ-027 run asserted outside IDLE is ignored.

Reset
REQ-028 rst in any state, including mid-instruction, forces IDLE in the next cycle; a pending dmem write is abandoned.
REQ-029 Reset values: pc=0, ir=0, R0-R3=0, zflag=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, alu_op=0, alu_in0=0, alu_in1=0, halted=0, busy=0.

Structure
REQ-030 Opcode constants SHALL live in the shared header def.h: AND=0, OR=1, ADD=2, SUB=3, INC=4, DEC=5, COMP=6, CHECK=7, LOAD=8, STORE=9, LI=10, R_90=11, R_180=12, JZ=13, JMP=14, HALT=15.
REQ-031 FSM state encodings SHALL be local constants in ctrl_unit.
REQ-032 The register file SHALL be one sub-module, regfile4x8: two async read ports and one sync write port.

Verification
REQ-033 Program LI R1,5; LI R2,3; ADD R1,R2; HALT -> R1=8 and halted=1 after 16 cycles.
REQ-034 STORE R1 -> [R2] with R1=0x5A, R2=0x10 -> one-cycle dmem_we with addr=0x10 and wdata=0x5A; a following LOAD R3 from 0x10 -> R3=0x5A.
REQ-035 CHECK R0,0 with R0=0, then JZ 0x20 -> pc=0x20; CHECK R0,1 then JZ 0x20 -> pc advances by 1.
REQ-036 R_90 with imm=1 and R[rs]=0x01 -> alu_op=11, alu_in0=1, alu_in1=0x01; rd receives alu_out.
REQ-037 rst asserted during MEM of a STORE -> no dmem_we pulse, IDLE next cycle, all outputs at reset values.
REQ-038 JMP 0xFF followed by the instruction at 0xFF -> pc wraps to 0x00.
